// File: rtl/imem_loader.sv
// Streaming instruction-memory loader: parses a length/payload/XOR-checksum byte
// frame and writes assembled little-endian words into the imem BSRAM.
module imem_loader #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [31:0]       mem_din,
  output logic              busy,
  output logic              cpu_reset,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_CSUM
  } state_t;

  state_t      state, state_nx;
  logic [15:0] len;
  logic [15:0] len_nx;
  logic [7:0]  csum;
  logic [23:0] asm_q;
  logic [1:0]  bcnt;
  logic        xfer;
  logic        len_bad;
  logic        last_word;

  assign xfer      = s_valid && s_ready;
  assign len_nx    = {s_data, len[7:0]};
  assign len_bad   = 32'(len_nx) > (32'd1 << ADDR_W);
  assign last_word = (32'(words) + 32'd1) == 32'(len);
  assign cpu_reset = busy;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LEN0;
      S_LEN0:  if (xfer) state_nx = S_LEN1;
      S_LEN1: begin
        if (xfer) begin
          if (len_bad)              state_nx = S_IDLE;
          else if (len_nx == 16'd0) state_nx = S_CSUM;
          else                      state_nx = S_DATA;
        end
      end
      S_DATA:  if (xfer && bcnt == 2'd3) state_nx = S_WRITE;
      S_WRITE: state_nx = last_word ? S_CSUM : S_DATA;
      S_CSUM:  if (xfer) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_ready <= 1'b0;
      mem_ce  <= 1'b0;
      mem_wre <= 1'b0;
      mem_ad  <= '0;
      mem_din <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      words   <= '0;
      len     <= '0;
      csum    <= '0;
      asm_q   <= '0;
      bcnt    <= '0;
    end else begin
      s_ready <= (state_nx == S_LEN0) || (state_nx == S_LEN1) ||
                 (state_nx == S_DATA) || (state_nx == S_CSUM);
      busy    <= (state_nx != S_IDLE);
      mem_ce  <= (state_nx == S_WRITE);
      mem_wre <= (state_nx == S_WRITE);
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err    <= 1'b0;
            words  <= '0;
            mem_ad <= '0;
            csum   <= '0;
            bcnt   <= '0;
          end
        end
        S_LEN0: if (xfer) len[7:0] <= s_data;
        S_LEN1: begin
          if (xfer) begin
            len[15:8] <= s_data;
            if (len_bad) begin
              err  <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            csum <= csum ^ s_data;
            bcnt <= bcnt + 2'd1;
            case (bcnt)
              2'd0:    asm_q[7:0]   <= s_data;
              2'd1:    asm_q[15:8]  <= s_data;
              2'd2:    asm_q[23:16] <= s_data;
              default: mem_din      <= {s_data, asm_q};
            endcase
          end
        end
        S_WRITE: begin
          words <= words + (ADDR_W+1)'(1);
          // Hold the address on the final word so a full-capacity load ends at the top address.
          if (!last_word) mem_ad <= mem_ad + ADDR_W'(1);
        end
        S_CSUM: begin
          if (xfer) begin
            done <= 1'b1;
            if (s_data != csum) err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Streaming loader that fills the 2048×32 instruction BSRAM from a byte stream, typically a UART receiver, before the core runs. It is the writer side of the instruction memory: the core only reads imem, and this block is the only thing that writes it. It parses a framed image (word count, little-endian payload, XOR checksum) and issues one BSRAM write per assembled word. It holds the core in reset while loading. The top level routes the imem port to this block while `busy`=1 and to the core fetch path otherwise.

## Interface
- `ADDR_W`, default 11: imem word-address width; capacity is 2**ADDR_W words.
- `clk` in 1: sole clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle pulse that arms a load. Honoured only in IDLE.
- `s_valid` in 1: byte-stream valid.
- `s_data` in 8: byte-stream data.
- `s_ready` out 1: loader can accept a byte. A transfer occurs when `s_valid && s_ready`.
- `mem_ce` out 1: BSRAM clock enable; high only on a write cycle.
- `mem_wre` out 1: BSRAM write enable; high only on a write cycle.
- `mem_ad` out ADDR_W: word address.
- `mem_din` out 32: write data.
- `busy` out 1: load in progress; also the imem port-mux select.
- `cpu_reset` out 1: equals `busy`; holds the core in reset.
- `done` out 1: one-cycle pulse when the frame ends, on both success and error.
- `err` out 1: sticky error flag; cleared on an accepted `start` or on `reset`.
- `words` out ADDR_W+1: count of words written in the current/last load.

## Operation
- Frame format: LEN_LO, LEN_HI (N, 16-bit LE), then 4N payload bytes (each word LE, byte0 = bits[7:0]), then CSUM. CSUM is the XOR of all payload bytes; length bytes are excluded.
- States and transitions:
  - IDLE: `start` → LEN0; clear `err`, `words`, address, running XOR.
  - LEN0: accept LEN_LO → LEN1.
  - LEN1: accept LEN_HI.
    - N > 2**ADDR_W: set `err`, pulse `done`, → IDLE. No writes occur.
    - N = 0: → CSUM.
    - Otherwise: → DATA.
  - DATA: accept 4 bytes into the assembly register, XOR each into the running checksum. On the 4th byte → WRITE.
  - WRITE (one cycle): `s_ready`=0; `mem_ce`=`mem_wre`=1; `mem_ad`=current address; `mem_din`=assembled word. Then increment address and `words`. If `words` reaches N → CSUM, else → DATA.
  - CSUM: accept one byte. If it ≠ running XOR, set `err`. Pulse `done`; → IDLE.
- `s_ready`=1 exactly in LEN0, LEN1, DATA, CSUM. `busy`=1 in every state except IDLE.
- `mem_ad`, `mem_din` and all control outputs come from registers. There is no combinational path from `s_valid`/`s_data` to any output except through state.
- `start` while busy: ignored. Bytes arriving in IDLE are not accepted (`s_ready`=0).
- Address wrap: cannot occur, because N is bounded to 2**ADDR_W. A full 2048-word load ends at address 2047.
- Reset mid-load: return to IDLE; all outputs 0. Words already written stay in BSRAM; there is no rollback.

## Timing
- Reset values: `s_ready`=0, `mem_ce`=0, `mem_wre`=0, `mem_ad`=0, `mem_din`=0, `busy`=0, `cpu_reset`=0, `done`=0, `err`=0, `words`=0.
- `start` at edge k → `busy`=1 and `s_ready`=1 from cycle k+1.
- Sustained input: one byte per cycle, except one stall cycle (WRITE) per word. Peak throughput is 4 bytes per 5 cycles.
- Write timing: the 4th payload byte is accepted at edge t. The BSRAM write is presented in cycle t+1 and committed at edge t+2.
- CSUM byte accepted at edge c → `done`=1 for cycle c+1 with final `err` valid. `busy`=0 from cycle c+1.
- Length-error path: LEN_HI accepted at edge e → `done`=1 and `err`=1 in cycle e+1.

## Test plan
- N=1, bytes 01 00 93 00 50 00 C3 → one write: `mem_ad`=0, `mem_din`=0x00500093. Then `done` pulse, `err`=0, `words`=1.
- N=2, bytes 02 00 93 00 50 00 13 01 10 00 C1 → writes 0x00500093@0 and 0x00100113@1. `err`=0, `words`=2. Exactly 1 `s_ready`-low cycle after each word.
- Same 2-word frame with CSUM=C0 → both words written, `done` pulse with `err`=1. `err` stays 1 until the next `start`.
- Length bytes 01 08 (N=2049) → no `mem_wre` ever asserted. `done`+`err` one cycle after LEN_HI. Back in IDLE.
- N=0 (00 00 00) → no writes, `err`=0. A CSUM byte of 5A instead gives `err`=1.
- `reset` asserted during the 3rd byte of word 1 in a 4-word load → next cycle all outputs 0, IDLE. Word 0 is still readable from BSRAM. A subsequent clean load succeeds.
